// File: rtl/snake_collision_checker_if.sv
// Controller handshake plus segment-RAM read port for the snake collision checker.
// master = movement controller / RAM side, slave = checker.
interface snake_collision_checker_if #(
    parameter int ADDR_W = 11,
    parameter int X_W    = 8,
    parameter int Y_W    = 7
);
    logic                 start;
    logic [X_W-1:0]       head_x;
    logic [Y_W-1:0]       head_y;
    logic [ADDR_W-1:0]    length;
    logic                 busy;
    logic                 done;
    logic                 hit_wall;
    logic                 hit_self;
    logic                 dead;
    logic                 rd_en;
    logic [ADDR_W-1:0]    rd_addr;
    logic [X_W+Y_W-1:0]   rd_data;

    modport master (
        output start, head_x, head_y, length, rd_data,
        input  busy, done, hit_wall, hit_self, dead, rd_en, rd_addr
    );

    modport slave (
        input  start, head_x, head_y, length, rd_data,
        output busy, done, hit_wall, hit_self, dead, rd_en, rd_addr
    );
endinterface

// File: rtl/snake_collision_checker.sv
// Checks a proposed snake head against the playfield walls and, via a pipelined
// read-back of the segment RAM, against the snake's own body.
module snake_collision_checker #(
    parameter int ADDR_W      = 11,
    parameter int X_W         = 8,
    parameter int Y_W         = 7,
    parameter int SCREEN_W    = 160,
    parameter int SCREEN_H    = 120,
    parameter int IGNORE_TAIL = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    snake_collision_checker_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [ADDR_W-1:0]   n_q, n_d;
    logic [X_W-1:0]      head_x_q, head_x_d;
    logic [Y_W-1:0]      head_y_q, head_y_d;
    logic                wall_q, wall_d;
    logic                pend_q, pend_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                hit_wall_q, hit_wall_d;
    logic                hit_self_q, hit_self_d;
    logic                dead_q, dead_d;

    logic                accept;
    logic                wall_start;
    logic [ADDR_W-1:0]   n_start;
    logic                match;

    assign accept     = bus.start & ((state_q == IDLE) | (state_q == DONE));
    assign wall_start = ({1'b0, bus.head_x} >= (X_W+1)'(SCREEN_W)) |
                        ({1'b0, bus.head_y} >= (Y_W+1)'(SCREEN_H));
    assign n_start    = (bus.length > ADDR_W'(IGNORE_TAIL)) ?
                        bus.length - ADDR_W'(IGNORE_TAIL) : '0;
    // pend_q marks that rd_data holds the segment addressed two edges ago
    assign match      = pend_q & (bus.rd_data == {head_x_q, head_y_q});

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        n_d        = n_q;
        head_x_d   = head_x_q;
        head_y_d   = head_y_q;
        wall_d     = wall_q;
        pend_d     = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        hit_wall_d = hit_wall_q;
        hit_self_d = hit_self_q;
        dead_d     = dead_q;
        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    head_x_d   = bus.head_x;
                    head_y_d   = bus.head_y;
                    n_d        = n_start;
                    wall_d     = wall_start;
                    idx_d      = '0;
                    busy_d     = 1'b1;
                    hit_wall_d = 1'b0;
                    hit_self_d = 1'b0;
                    dead_d     = 1'b0;
                    // Wall hits and empty scans idle one cycle in DRAIN with nothing in flight
                    state_d    = (wall_start || n_start == '0) ? DRAIN : SCAN;
                end else begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            SCAN: begin
                pend_d = 1'b1;
                idx_d  = idx_q + ADDR_W'(1);
                if (match) begin
                    pend_d     = 1'b0;
                    hit_self_d = 1'b1;
                    dead_d     = 1'b1;
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = DONE;
                end else if (idx_q == n_q - ADDR_W'(1)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                hit_wall_d = wall_q;
                hit_self_d = match;
                dead_d     = wall_q | match;
                done_d     = 1'b1;
                busy_d     = 1'b0;
                state_d    = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            pend_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            hit_wall_q <= 1'b0;
            hit_self_q <= 1'b0;
            dead_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            pend_q     <= pend_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            hit_wall_q <= hit_wall_d;
            hit_self_q <= hit_self_d;
            dead_q     <= dead_d;
        end
    end

    always_ff @(posedge clk) begin
        head_x_q <= head_x_d;
        head_y_q <= head_y_d;
        n_q      <= n_d;
        wall_q   <= wall_d;
    end

    assign bus.rd_en    = (state_q == SCAN);
    assign bus.rd_addr  = idx_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.hit_wall = hit_wall_q;
    assign bus.hit_self = hit_self_q;
    assign bus.dead     = dead_q;
endmodule

// File: tb/tb_snake_collision_checker.sv
// Directed bench for snake_collision_checker: two instances (IGNORE_TAIL 1 and 0)
// sharing one segment RAM image, a vector table plus handwritten control sequences.
module tb_snake_collision_checker;
    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    snake_collision_checker_if #(.ADDR_W(11), .X_W(8), .Y_W(7)) if0 ();
    snake_collision_checker_if #(.ADDR_W(11), .X_W(8), .Y_W(7)) if1 ();

    snake_collision_checker #(.IGNORE_TAIL(1)) dut1 (.clk(clk), .reset_n(reset_n), .bus(if1));
    snake_collision_checker #(.IGNORE_TAIL(0)) dut0 (.clk(clk), .reset_n(reset_n), .bus(if0));

    logic [14:0] mem [0:2047];
    int          log0 [$];
    int          log1 [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (if1.rd_en) begin
            if1.rd_data <= mem[if1.rd_addr];
            log1.push_back(int'(if1.rd_addr));
        end
        if (if0.rd_en) begin
            if0.rd_data <= mem[if0.rd_addr];
            log0.push_back(int'(if0.rd_addr));
        end
    end

    typedef struct {
        int          sel;
        logic [7:0]  x;
        logic [6:0]  y;
        logic [10:0] len;
        int          lat;
        logic        w;
        logic        s;
        int          reads;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // {busy, done, hit_wall, hit_self, dead, rd_en}
    function automatic logic [5:0] status(input int sel);
        if (sel == 1)
            return {if1.busy, if1.done, if1.hit_wall, if1.hit_self, if1.dead, if1.rd_en};
        return {if0.busy, if0.done, if0.hit_wall, if0.hit_self, if0.dead, if0.rd_en};
    endfunction

    function automatic int log_size(input int sel);
        return (sel == 1) ? log1.size() : log0.size();
    endfunction

    function automatic int log_at(input int sel, input int j);
        return (sel == 1) ? log1[j] : log0[j];
    endfunction

    task automatic drive(input int sel, input logic s, input logic [7:0] x,
                         input logic [6:0] y, input logic [10:0] len);
        if (sel == 1) begin
            if1.start = s; if1.head_x = x; if1.head_y = y; if1.length = len;
        end else begin
            if0.start = s; if0.head_x = x; if0.head_y = y; if0.length = len;
        end
    endtask

    // Raises start for one edge; returns #1 after that edge.
    task automatic start_pulse(input int sel, input logic [7:0] x,
                               input logic [6:0] y, input logic [10:0] len);
        @(negedge clk);
        drive(sel, 1'b1, x, y, len);
        @(posedge clk);
        #1;
        drive(sel, 1'b0, x, y, len);
    endtask

    // Counts edges from the last sampled edge until done is seen; -1 on timeout.
    task automatic wait_done(input int sel, output int lat, output int bc, output int rc);
        logic [5:0] st;
        lat = -1;
        bc  = 0;
        rc  = 0;
        for (int c = 0; c < 200; c++) begin
            st = status(sel);
            if (st[4]) begin
                lat = c;
                break;
            end
            bc += int'(st[5]);
            rc += int'(st[0]);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int         lat, bc, rc, dcnt;
        logic [5:0] st;
        logic       exp_w, exp_s;
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        drive(0, 1'b0, 8'd0, 7'd0, 11'd0);
        drive(1, 1'b0, 8'd0, 7'd0, 11'd0);
        if0.rd_data = '0;
        if1.rd_data = '0;
        for (int i = 0; i < 2048; i++) mem[i] = 15'h7FFF;
        for (int i = 0; i < 5; i++) mem[i] = {8'(60 + i), 7'd60};

        //              sel  x        y       len     lat w     s     reads
        vecs[0]  = '{1, 8'd160, 7'd10,  11'd5, 1, 1'b1, 1'b0, 0};
        vecs[1]  = '{1, 8'd255, 7'd50,  11'd5, 1, 1'b1, 1'b0, 0};
        vecs[2]  = '{1, 8'd20,  7'd127, 11'd5, 1, 1'b1, 1'b0, 0};
        vecs[3]  = '{1, 8'd100, 7'd120, 11'd5, 1, 1'b1, 1'b0, 0};
        vecs[4]  = '{0, 8'd160, 7'd119, 11'd5, 1, 1'b1, 1'b0, 0};
        vecs[5]  = '{1, 8'd159, 7'd119, 11'd5, 5, 1'b0, 1'b0, 4};
        vecs[6]  = '{1, 8'd60,  7'd61,  11'd5, 5, 1'b0, 1'b0, 4};
        vecs[7]  = '{1, 8'd62,  7'd60,  11'd5, 4, 1'b0, 1'b1, 4};
        vecs[8]  = '{1, 8'd64,  7'd60,  11'd5, 5, 1'b0, 1'b0, 4};
        vecs[9]  = '{0, 8'd64,  7'd60,  11'd5, 6, 1'b0, 1'b1, 5};
        vecs[10] = '{1, 8'd60,  7'd60,  11'd5, 2, 1'b0, 1'b1, 2};
        vecs[11] = '{1, 8'd10,  7'd10,  11'd0, 1, 1'b0, 1'b0, 0};
        vecs[12] = '{1, 8'd60,  7'd60,  11'd1, 1, 1'b0, 1'b0, 0};
        vecs[13] = '{0, 8'd60,  7'd60,  11'd1, 2, 1'b0, 1'b1, 1};
        vecs[14] = '{0, 8'd10,  7'd10,  11'd0, 1, 1'b0, 1'b0, 0};

        repeat (3) @(posedge clk);
        #1;
        check("reset status dut1", int'(status(1)), 0);
        check("reset status dut0", int'(status(0)), 0);
        check("reset rd_addr dut1", int'(if1.rd_addr), 0);
        check("reset rd_addr dut0", int'(if0.rd_addr), 0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            if (vecs[i].sel == 1) log1.delete(); else log0.delete();
            start_pulse(vecs[i].sel, vecs[i].x, vecs[i].y, vecs[i].len);
            wait_done(vecs[i].sel, lat, bc, rc);
            st = status(vecs[i].sel);
            check($sformatf("v%0d latency", i), lat, vecs[i].lat);
            check($sformatf("v%0d hit_wall", i), int'(st[3]), int'(vecs[i].w));
            check($sformatf("v%0d hit_self", i), int'(st[2]), int'(vecs[i].s));
            check($sformatf("v%0d dead", i), int'(st[1]), int'(vecs[i].w | vecs[i].s));
            check($sformatf("v%0d busy low in done cycle", i), int'(st[5]), 0);
            check($sformatf("v%0d busy cycles", i), bc, vecs[i].lat);
            check($sformatf("v%0d rd_en cycles", i), rc, vecs[i].reads);
            @(posedge clk);
            #1;
            st = status(vecs[i].sel);
            check($sformatf("v%0d done one cycle", i), int'(st[4]), 0);
            check($sformatf("v%0d flags held", i), int'(st[3:1]),
                  int'({vecs[i].w, vecs[i].s, vecs[i].w | vecs[i].s}));
            check($sformatf("v%0d reads issued", i), log_size(vecs[i].sel), vecs[i].reads);
            for (int j = 0; j < log_size(vecs[i].sel); j++)
                check($sformatf("v%0d read addr %0d", i, j), log_at(vecs[i].sel, j), j);
        end

        // start while busy must be ignored, including its wall-violating head
        start_pulse(1, 8'd60, 7'd61, 11'd5);
        start_pulse(1, 8'd160, 7'd0, 11'd5);
        wait_done(1, lat, bc, rc);
        st = status(1);
        check("busy start ignored latency", lat, 4);
        check("busy start ignored hit_wall", int'(st[3]), 0);
        check("busy start ignored dead", int'(st[1]), 0);

        // back-to-back: new start in the done cycle of a self hit
        start_pulse(1, 8'd62, 7'd60, 11'd5);
        wait_done(1, lat, bc, rc);
        st = status(1);
        check("b2b first latency", lat, 4);
        check("b2b first hit_self", int'(st[2]), 1);
        start_pulse(1, 8'd160, 7'd10, 11'd5);
        st = status(1);
        check("b2b flags cleared", int'(st[3:1]), 0);
        check("b2b busy", int'(st[5]), 1);
        check("b2b done dropped", int'(st[4]), 0);
        wait_done(1, lat, bc, rc);
        st = status(1);
        check("b2b second latency", lat, 1);
        check("b2b second flags", int'(st[3:1]), 3'b101);

        // asynchronous reset in the middle of a scan
        start_pulse(1, 8'd60, 7'd61, 11'd5);
        @(posedge clk);
        #1;
        check("mid-scan rd_en before reset", int'(if1.rd_en), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid-scan reset status", int'(status(1)), 0);
        check("mid-scan reset rd_addr", int'(if1.rd_addr), 0);
        dcnt = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            dcnt += int'(if1.done);
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            dcnt += int'(if1.done) + int'(if1.busy);
        end
        check("no done after reset abort", dcnt, 0);

        // a check after the abort still works
        start_pulse(1, 8'd61, 7'd60, 11'd5);
        wait_done(1, lat, bc, rc);
        st = status(1);
        exp_w = 1'b0;
        exp_s = 1'b1;
        check("post-reset latency", lat, 3);
        check("post-reset flags", int'(st[3:1]), int'({exp_w, exp_s, exp_w | exp_s}));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
